// File: rtl/scan_pkg.sv
// Shared definitions for the serial scan engine.
//   state_e : transaction states (IDLE, SHIFT, DONE)
//   out_idx : shift-register bit that drives serial_out
//   in_idx  : shift-register bit that receives serial_in
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_SHIFT = 2'd1;
  localparam logic [1:0] ENC_DONE  = 2'd2;

  // LSB-first words leave from bit 0; MSB-first words leave from the top bit.
  function automatic int out_idx(input int width, input bit lsb_first);
    return lsb_first ? 0 : width - 1;
  endfunction

  // Captured bits enter at the end opposite to the output end.
  function automatic int in_idx(input int width, input bit lsb_first);
    return lsb_first ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/scan_bit_counter.sv
// Bit counter for one scan transaction.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (wins over en)
//   en       : advance count by one
//   last     : count == WIDTH-1, i.e. the next enabled shift is the final one
module scan_bit_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The engine clears on the final shift, so the count never has to
  // represent WIDTH and cannot wrap.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == LAST_CNT);

endmodule

// File: rtl/scan_shift_engine.sv
// Serial scan engine: loads a parallel word, shifts it out one bit per
// enabled cycle while capturing serial_in into the vacated positions, and
// returns the captured word with a one-cycle valid pulse.
//   clk, rst    : clock, synchronous active-high reset
//   load_valid  : parallel word offered
//   load_ready  : engine accepts a word this cycle (IDLE only)
//   load_data   : parallel word to shift out
//   shift_en    : advance one bit this cycle (low = stall)
//   abort       : cancel the transaction in SHIFT
//   serial_in   : serial capture input
//   serial_out  : serial output, 0 outside SHIFT
//   busy        : SHIFT or DONE
//   cap_valid   : one-cycle pulse, cap_data holds a new word
//   cap_data    : last completed captured word
//   dbg_state   : current FSM state
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both 1; load_valid is ignored whenever load_ready is 0.
module scan_shift_engine
  import scan_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             abort,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             busy,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_data,
  output state_e           dbg_state
);

  localparam int OUT_IDX = out_idx(WIDTH, LSB_FIRST);
  localparam int IN_IDX  = in_idx(WIDTH, LSB_FIRST);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] cap_data_q, cap_data_d;
  logic             cap_valid_q, cap_valid_d;
  logic [WIDTH-1:0] sr_shifted;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_last;

  scan_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  // Register contents after one shift: move away from the input end and
  // drop serial_in into the freed slot.
  always_comb begin
    if (LSB_FIRST) begin
      sr_shifted = sr_q >> 1;
    end else begin
      sr_shifted = sr_q << 1;
    end
    sr_shifted[IN_IDX] = serial_in;
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cap_data_d  = cap_data_q;
    cap_valid_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          sr_d    = load_data;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // abort takes precedence, even over the final shift.
        if (abort) begin
          sr_d    = '0;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (shift_en) begin
          sr_d = sr_shifted;
          if (cnt_last) begin
            cap_data_d  = sr_shifted;
            cap_valid_d = 1'b1;
            cnt_clr     = 1'b1;
            state_d     = ST_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cap_data_q  <= cap_data_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign serial_out = (state_q == ST_SHIFT) && sr_q[OUT_IDX];
  assign cap_valid  = cap_valid_q;
  assign cap_data   = cap_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_scan_shift_engine.sv
// Bench for scan_shift_engine: an LSB-first and an MSB-first instance share
// all inputs; each is compared every cycle against a word-level model.
module tb_scan_shift_engine;
  import scan_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         shift_en;
  logic         abort;
  logic         serial_in;

  logic         lr   [2];
  logic         so   [2];
  logic         bz   [2];
  logic         cv   [2];
  logic [W-1:0] cd   [2];
  state_e       st   [2];

  scan_shift_engine #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr[0]),
    .load_data(load_data), .shift_en(shift_en), .abort(abort),
    .serial_in(serial_in), .serial_out(so[0]), .busy(bz[0]),
    .cap_valid(cv[0]), .cap_data(cd[0]), .dbg_state(st[0])
  );

  scan_shift_engine #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr[1]),
    .load_data(load_data), .shift_en(shift_en), .abort(abort),
    .serial_in(serial_in), .serial_out(so[1]), .busy(bz[1]),
    .cap_valid(cv[1]), .cap_data(cd[1]), .dbg_state(st[1])
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level model: phase 0 idle, 1 shifting, 2 done.
  // Instance 0 is LSB-first, instance 1 MSB-first.
  int           m_phase [2];
  int           m_k     [2];
  logic [W-1:0] m_word  [2];
  logic [W-1:0] m_acc   [2];
  logic [W-1:0] m_cap   [2];

  function automatic void model_update(input int i);
    if (rst) begin
      m_phase[i] = 0; m_k[i] = 0; m_word[i] = '0; m_acc[i] = '0; m_cap[i] = '0;
    end else begin
      case (m_phase[i])
        0: if (load_valid) begin
          m_word[i] = load_data; m_k[i] = 0; m_acc[i] = '0; m_phase[i] = 1;
        end
        1: if (abort) begin
          m_phase[i] = 0; m_k[i] = 0;
        end else if (shift_en) begin
          // The j-th received bit lands at bit j (LSB-first) or W-1-j.
          if (i == 0) m_acc[i][m_k[i]] = serial_in;
          else        m_acc[i][W-1-m_k[i]] = serial_in;
          m_k[i]++;
          if (m_k[i] == W) begin
            m_cap[i] = m_acc[i]; m_phase[i] = 2;
          end
        end
        default: m_phase[i] = 0;
      endcase
    end
  endfunction

  function automatic logic model_so(input int i);
    if (m_phase[i] != 1) return 1'b0;
    return (i == 0) ? m_word[i][m_k[i]] : m_word[i][W-1-m_k[i]];
  endfunction

  task automatic compare_all();
    state_e es;
    for (int i = 0; i < 2; i++) begin
      es = (m_phase[i] == 0) ? ST_IDLE : (m_phase[i] == 1) ? ST_SHIFT : ST_DONE;
      check($sformatf("ready%0d", i), 32'(lr[i]), 32'(m_phase[i] == 0));
      check($sformatf("busy%0d", i),  32'(bz[i]), 32'(m_phase[i] != 0));
      check($sformatf("cvalid%0d", i), 32'(cv[i]), 32'(m_phase[i] == 2));
      check($sformatf("cdata%0d", i), 32'(cd[i]), 32'(m_cap[i]));
      check($sformatf("sout%0d", i),  32'(so[i]), 32'(model_so(i)));
      check($sformatf("state%0d", i), 32'(st[i]), 32'(es));
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic lv, input logic [W-1:0] ld,
                      input logic se, input logic ab, input logic si);
    rst = r; load_valid = lv; load_data = ld; shift_en = se; abort = ab; serial_in = si;
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] out_pat;
  logic [W-1:0] in_pat;
  int           n_en;
  int           n_pulse;
  int           first_at;
  int           second_at;
  logic         se_v;

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0;
    shift_en = 1'b0; abort = 1'b0; serial_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_k[i] = 0; m_word[i] = '0; m_acc[i] = '0; m_cap[i] = '0;
    end

    // Reset values.
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(lr[i]), 32'd1);
      check("rst_busy",  32'(bz[i]), 32'd0);
      check("rst_sout",  32'(so[i]), 32'd0);
      check("rst_cdata", 32'(cd[i]), 32'd0);
    end

    // Directed: load 0xA5, capture 0x3C. Both patterns read the same in
    // either bit order, so one serial_in stream serves both instances.
    out_pat = 8'hA5;
    in_pat  = 8'h3C;
    step(0, 1, out_pat, 0, 0, 0);
    for (int j = 0; j < W; j++) begin
      for (int i = 0; i < 2; i++) begin
        check("dir_sout", 32'(so[i]), 32'(out_pat[W-1-j]));
        check("dir_ready", 32'(lr[i]), 32'd0);
      end
      step(0, 0, '0, 1, 0, in_pat[j]);
    end
    for (int i = 0; i < 2; i++) begin
      check("dir_cvalid", 32'(cv[i]), 32'd1);
      check("dir_cdata",  32'(cd[i]), 32'h3C);
      check("dir_ready9", 32'(lr[i]), 32'd0);
    end
    step(0, 0, '0, 0, 0, 0);
    check("dir_after_cvalid", 32'(cv[0]), 32'd0);

    // Stalls: shift_en pattern 1,0,0,1 repeating.
    step(0, 1, 8'(($urandom_range(0, 255))), 0, 0, 0);
    n_en = 0; n_pulse = 0;
    for (int c = 0; c < 40 && n_pulse == 0; c++) begin
      se_v = (c % 4 == 0) || (c % 4 == 3);
      step(0, 0, '0, se_v, 0, 1'($urandom_range(0, 1)));
      if (se_v) n_en++;
      if (cv[0]) n_pulse++;
    end
    check("stall_pulse", 32'(n_pulse), 32'd1);
    check("stall_shifts", 32'(n_en), 32'(W));
    step(0, 0, '0, 1, 0, 0);
    check("stall_one_pulse", 32'(cv[0]), 32'd0);

    // Abort after 3 shifts: cap_data keeps the previous word.
    step(0, 0, '0, 0, 0, 0);
    in_pat = cd[0];
    step(0, 1, 8'hFF, 0, 0, 0);
    for (int j = 0; j < 3; j++) step(0, 0, '0, 1, 0, 1'($urandom_range(0, 1)));
    step(0, 0, '0, 1, 1, 1);
    check("abort_ready", 32'(lr[0]), 32'd1);
    check("abort_busy",  32'(bz[0]), 32'd0);
    check("abort_sout",  32'(so[0]), 32'd0);
    check("abort_cvalid", 32'(cv[0]), 32'd0);
    check("abort_cdata_hold", 32'(cd[0]), 32'(m_cap[0]));

    // Abort coinciding with the final shift.
    step(0, 1, 8'h81, 0, 0, 0);
    for (int j = 0; j < W - 1; j++) step(0, 0, '0, 1, 0, 1);
    step(0, 0, '0, 1, 1, 1);
    check("abort8_ready", 32'(lr[0]), 32'd1);
    check("abort8_cvalid", 32'(cv[0]), 32'd0);
    step(0, 0, '0, 0, 0, 0);
    check("abort8_no_pulse", 32'(cv[0]), 32'd0);

    // Reset mid-SHIFT after 5 shifts, with cap_data holding a prior word.
    step(0, 1, 8'h0F, 0, 0, 0);
    for (int j = 0; j < W; j++) step(0, 0, '0, 1, 0, 1);
    step(0, 0, '0, 0, 0, 0);
    check("pre_rst_cdata", 32'(cd[0]), 32'hFF);
    step(0, 1, 8'hC3, 0, 0, 0);
    for (int j = 0; j < 5; j++) step(0, 0, '0, 1, 0, 1);
    step(1, 0, '0, 1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      check("midrst_cdata", 32'(cd[i]), 32'd0);
      check("midrst_ready", 32'(lr[i]), 32'd1);
      check("midrst_busy",  32'(bz[i]), 32'd0);
      check("midrst_sout",  32'(so[i]), 32'd0);
    end

    // load_valid held high: back-to-back words.
    n_pulse = 0; first_at = -1; second_at = -1;
    for (int c = 0; c < 22; c++) begin
      step(0, 1, 8'($urandom_range(0, 255)), 1, 0, 1'($urandom_range(0, 1)));
      if (cv[0]) begin
        n_pulse++;
        if (first_at < 0) first_at = c;
        else if (second_at < 0) second_at = c;
      end
    end
    check("b2b_pulses", 32'(n_pulse), 32'd2);
    check("b2b_spacing", 32'(second_at - first_at), 32'(W + 2));

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
